// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - shared CPU types and the multiply sequencer's port bundle
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;
endpackage

interface alu_mul_sequencer_if;
    import cpu_types_pkg::*;

    logic   start;
    word_t  mcand;
    word_t  mplier;
    logic   busy;
    logic   done;
    word_t  product;

    aluop_t dp_alu_op;
    word_t  dp_port_A;
    word_t  dp_port_B;

    aluop_t alu_op;
    word_t  port_A;
    word_t  port_B;
    word_t  alu_outport;

    // master is everything around the sequencer: execute stage plus the ALU result
    modport master (
        output start, mcand, mplier, dp_alu_op, dp_port_A, dp_port_B, alu_outport,
        input  busy, done, product, alu_op, port_A, port_B
    );

    modport slave (
        input  start, mcand, mplier, dp_alu_op, dp_port_A, dp_port_B, alu_outport,
        output busy, done, product, alu_op, port_A, port_B
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add multiply controller borrowing the shared single-cycle ALU
module alu_mul_sequencer #(
    parameter int EARLY_EXIT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    alu_mul_sequencer_if.slave   bus
);
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    word_t      acc;
    word_t      mc;
    word_t      mp;
    logic [5:0] cnt;

    logic accept;
    logic run_last;

    // start is only honoured outside RUN; DONE accepts it for back-to-back operation
    assign accept   = bus.start && ((state == IDLE) || (state == DONE));
    assign run_last = (EARLY_EXIT != 0) ? ((mp >> 1) == 32'd0) : (cnt == 6'd31);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if ((EARLY_EXIT != 0) && (bus.mplier == 32'd0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
            mc  <= '0;
            mp  <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= '0;
            mc  <= bus.mcand;
            mp  <= bus.mplier;
            cnt <= '0;
        end else if (state == RUN) begin
            // the ALU is computing acc + mc this cycle; keep it only for set multiplier bits
            if (mp[0]) begin
                acc <= bus.alu_outport;
            end
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + 6'd1;
        end
    end

    always_comb begin
        bus.busy    = (state == RUN);
        bus.done    = (state == DONE);
        bus.product = acc;
        bus.alu_op  = bus.dp_alu_op;
        bus.port_A  = bus.dp_port_A;
        bus.port_B  = bus.dp_port_B;
        if (state == RUN) begin
            bus.alu_op = ALU_ADD;
            bus.port_A = acc;
            bus.port_B = mc;
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized self-checking bench for alu_mul_sequencer (both EARLY_EXIT values)
module tb_alu_mul_sequencer;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mul_sequencer_if m0 ();
    alu_mul_sequencer_if m1 ();

    alu_mul_sequencer #(.EARLY_EXIT(1)) u_ee1 (.CLK(clk), .RST(rst), .bus(m0.slave));
    alu_mul_sequencer #(.EARLY_EXIT(0)) u_ee0 (.CLK(clk), .RST(rst), .bus(m1.slave));

    logic   st     [2];
    word_t  mc_in  [2];
    word_t  mp_in  [2];
    aluop_t dp_op;
    word_t  dp_a;
    word_t  dp_b;

    logic   ob_busy [2];
    logic   ob_done [2];
    word_t  ob_prod [2];
    aluop_t ob_op   [2];
    word_t  ob_pa   [2];
    word_t  ob_pb   [2];

    function automatic word_t alu_f(input aluop_t op, input word_t a, input word_t b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign m0.start = st[0];     assign m1.start = st[1];
    assign m0.mcand = mc_in[0];  assign m1.mcand = mc_in[1];
    assign m0.mplier = mp_in[0]; assign m1.mplier = mp_in[1];
    assign m0.dp_alu_op = dp_op; assign m1.dp_alu_op = dp_op;
    assign m0.dp_port_A = dp_a;  assign m1.dp_port_A = dp_a;
    assign m0.dp_port_B = dp_b;  assign m1.dp_port_B = dp_b;
    assign m0.alu_outport = alu_f(m0.alu_op, m0.port_A, m0.port_B);
    assign m1.alu_outport = alu_f(m1.alu_op, m1.port_A, m1.port_B);

    assign ob_busy[0] = m0.busy;    assign ob_busy[1] = m1.busy;
    assign ob_done[0] = m0.done;    assign ob_done[1] = m1.done;
    assign ob_prod[0] = m0.product; assign ob_prod[1] = m1.product;
    assign ob_op[0]   = m0.alu_op;  assign ob_op[1]   = m1.alu_op;
    assign ob_pa[0]   = m0.port_A;  assign ob_pa[1]   = m1.port_A;
    assign ob_pb[0]   = m0.port_B;  assign ob_pb[1]   = m1.port_B;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RUN length: one cycle per multiplier bit up to the highest set one, or always 32
    function automatic int ref_n(input word_t b, input bit early);
        int n;
        if (!early) return 32;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    task automatic issue(input int d, input word_t a, input word_t b);
        st[d]    = 1'b1;
        mc_in[d] = a;
        mp_in[d] = b;
        @(posedge clk);
        #1;
        st[d]    = 1'b0;
        mc_in[d] = $urandom;
        mp_in[d] = $urandom;
    endtask

    task automatic check_idle_mux(input int d, input string tag);
        dp_op = aluop_t'($urandom_range(0, 9));
        dp_a  = $urandom;
        dp_b  = $urandom;
        #1;
        check({tag, "_op"}, 64'(ob_op[d]), 64'(dp_op));
        check({tag, "_a"},  64'(ob_pa[d]), 64'(dp_a));
        check({tag, "_b"},  64'(ob_pb[d]), 64'(dp_b));
    endtask

    // Called just after the accept edge; returns at the falling edge inside DONE
    task automatic await_done(input int d, input word_t a, input word_t b, input string tag);
        int          cyc;
        bit          fin;
        logic [63:0] part;
        word_t       exp_a;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (ob_done[d]) begin
                fin = 1'b1;
                check({tag, "_excl"},   64'(ob_busy[d]), 64'd0);
                check({tag, "_cycles"}, 64'(cyc), 64'(ref_n(b, d == 0)));
                check({tag, "_product"}, 64'(ob_prod[d]), 64'(word_t'(a * b)));
            end else if (!ob_busy[d] || cyc >= 40) begin
                fin = 1'b1;
                check({tag, "_done"}, 64'(ob_done[d]), 64'd1);
            end else begin
                dp_op = aluop_t'($urandom_range(0, 9));
                dp_a  = $urandom;
                dp_b  = $urandom;
                #1;
                part  = 64'(b) & ((64'd1 << cyc) - 64'd1);
                exp_a = word_t'(64'(a) * part);
                check({tag, "_run_op"}, 64'(ob_op[d]), 64'(ALU_ADD));
                check({tag, "_run_a"},  64'(ob_pa[d]), 64'(exp_a));
                check({tag, "_run_b"},  64'(ob_pb[d]), 64'(word_t'(a << cyc)));
                cyc++;
            end
        end
    endtask

    initial begin
        word_t a;
        word_t b;
        int    d;
        bit    seen;

        st[0] = 1'b0; st[1] = 1'b0;
        mc_in[0] = '0; mc_in[1] = '0;
        mp_in[0] = '0; mp_in[1] = '0;
        dp_op = ALU_SUB;
        dp_a  = 32'd10;
        dp_b  = 32'd4;
        rst   = 1'b1;
        #12;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", 64'(ob_busy[k]), 64'd0);
            check("rst_done", 64'(ob_done[k]), 64'd0);
            check("rst_product", 64'(ob_prod[k]), 64'd0);
            check("idle_sub_op", 64'(ob_op[k]), 64'(ALU_SUB));
            check("idle_sub_a", 64'(ob_pa[k]), 64'd10);
            check("idle_sub_b", 64'(ob_pb[k]), 64'd4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 32'd3, 32'd5);
        await_done(0, 32'd3, 32'd5, "m3x5");
        @(negedge clk);
        check("m3x5_idle_busy", 64'(ob_busy[0]), 64'd0);
        check("m3x5_idle_done", 64'(ob_done[0]), 64'd0);
        check("m3x5_hold", 64'(ob_prod[0]), 64'd15);

        issue(0, 32'h1234, 32'd0);
        await_done(0, 32'h1234, 32'd0, "mzero");
        @(negedge clk);

        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        await_done(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mones_ee1");
        @(negedge clk);
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        await_done(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mones_ee0");
        @(negedge clk);
        issue(1, 32'h1234, 32'd0);
        await_done(1, 32'h1234, 32'd0, "mzero_ee0");
        @(negedge clk);

        issue(0, 32'hFFFF_FFFD, 32'd7);
        await_done(0, 32'hFFFF_FFFD, 32'd7, "mneg3x7");
        issue(0, 32'd2, 32'd2);
        await_done(0, 32'd2, 32'd2, "b2b_2x2");
        @(negedge clk);

        dp_op = ALU_SUB;
        dp_a  = 32'd10;
        dp_b  = 32'd4;
        #1;
        check("arb_idle_op", 64'(ob_op[0]), 64'(ALU_SUB));
        check("arb_idle_a", 64'(ob_pa[0]), 64'd10);
        check("arb_idle_b", 64'(ob_pb[0]), 64'd4);
        @(negedge clk);

        issue(0, 32'h8000_0000, 32'h8000_0000);
        repeat (4) @(negedge clk);
        check("abort_busy_before", 64'(ob_busy[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(ob_busy[0]), 64'd0);
        check("abort_done", 64'(ob_done[0]), 64'd0);
        check("abort_product", 64'(ob_prod[0]), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | ob_done[0];
        end
        check("abort_no_done", 64'(seen), 64'd0);
        issue(0, 32'd7, 32'd9);
        await_done(0, 32'd7, 32'd9, "after_abort");
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            d = (i % 4 == 3) ? 1 : 0;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 7 == 0) b = '0;
            check_idle_mux(d, "rnd_idle");
            @(negedge clk);
            issue(d, a, b);
            await_done(d, a, b, "rnd");
            @(negedge clk);
            check("rnd_hold", 64'(ob_prod[d]), 64'(word_t'(a * b)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle multiply controller that shares the single-cycle ALU with the datapath. While idle it passes the datapath's ALU request straight through. On `start` it takes ownership of the ALU and runs a shift-add multiply, issuing one `ALU_ADD` per cycle. It returns the low 32 bits of the product and raises `done` for one cycle. It sits between the datapath's execute stage and the ALU's `aluport` modport, using `aluop_t`/`word_t` from `cpu_types_pkg`.

## Interface
Parameters:
- `EARLY_EXIT`, default 1. When 1, the sequence ends once the remaining multiplier is zero. When 0, it always runs 32 iterations.

Ports:
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply. Sampled only in IDLE or DONE.
- `mcand` in 32 (`word_t`): multiplicand, captured when `start` is accepted.
- `mplier` in 32 (`word_t`): multiplier, captured when `start` is accepted.
- `busy` out 1: high in RUN. The datapath stalls ALU use while it is high.
- `done` out 1: one-cycle pulse in DONE.
- `product` out 32 (`word_t`): accumulator. Valid while `done` is high and held until the next accepted `start`.
- `dp_alu_op` in `aluop_t`, `dp_port_A` in 32, `dp_port_B` in 32: datapath ALU request.
- `alu_op` out `aluop_t`, `port_A` out 32, `port_B` out 32: to the ALU.
- `alu_outport` in 32: ALU result.

## Operation
- States: IDLE, RUN, DONE. Registers: `acc` (32), `mc` (32), `mp` (32), `cnt` (6).
- IDLE, `start`=1:
  - `acc`<=0, `mc`<=`mcand`, `mp`<=`mplier`, `cnt`<=0.
  - Next state is RUN, or DONE if `EARLY_EXIT`=1 and `mplier`==0.
- IDLE, `start`=0: stay in IDLE.
- RUN, each cycle:
  - ALU driven with `alu_op`=`ALU_ADD`, `port_A`=`acc`, `port_B`=`mc`.
  - If `mp[0]`: `acc`<=`alu_outport`.
  - `mc`<=`mc`<<1, `mp`<=`mp`>>1 (logical), `cnt`<=`cnt`+1. The shifts are local; they do not use the ALU.
- RUN exit to DONE:
  - `EARLY_EXIT`=1: when (`mp`>>1)==0.
  - `EARLY_EXIT`=0: when `cnt`==31.
- DONE:
  - `done`=1 for one cycle.
  - With `start`=1, behave exactly as IDLE with `start`=1 (back-to-back multiplies). Otherwise go to IDLE.
- `start` in RUN is ignored: not queued and no error.
- Arithmetic is modulo 2^32; the ALU overflow flag is ignored. The low word is identical for signed and unsigned operands.
- ALU mux:
  - In RUN, the sequencer drives the ALU ports.
  - In IDLE and DONE, `alu_op`/`port_A`/`port_B` equal `dp_alu_op`/`dp_port_A`/`dp_port_B` combinationally.
  - `alu_outport` and flags reach the datapath directly; this block does not reroute them.

## Timing
- Reset, asynchronous: state=IDLE; `acc`, `mc`, `mp`, `cnt`=0; `busy`=0; `done`=0; `product`=0.
- Mux outputs in IDLE follow the datapath inputs.
- Reset asserted mid-RUN aborts the multiply immediately with the values above. No `done` is produced.
- Let `start` be accepted at edge t0.
- N = number of RUN cycles:
  - `EARLY_EXIT`=1: N = (index of highest set bit of `mplier`)+1, or 0 if `mplier`==0.
  - `EARLY_EXIT`=0: N = 32.
- Timeline:
  - `busy`=1 from t0 to t0+N.
  - `done`=1 during the cycle after edge t0+N.
  - Total latency from the accept edge to `done` high is N cycles of RUN plus entry into DONE.
- `product` becomes final at edge t0+N and holds until the next accepted `start` clears `acc`.
- `busy` and `done` are registered-state decodes and are never high together.

## Test plan
- `mcand`=3, `mplier`=5, `EARLY_EXIT`=1 -> `busy` high for 3 cycles, then `done` pulse with `product`=15; next cycle IDLE, `product` still 15.
- `mplier`=0, `mcand`=0x1234 -> no RUN cycles, DONE on the cycle after accept, `product`=0, `busy` never high.
- `mcand`=`mplier`=0xFFFFFFFF -> 32 RUN cycles (either parameter value), `product`=0x00000001. Check `alu_op`=`ALU_ADD` every RUN cycle.
- `mcand`=0xFFFFFFFD (-3), `mplier`=7 -> `product`=0xFFFFFFEB. `start` held high in DONE begins `mcand`=2, `mplier`=2 back-to-back -> `product`=4.
- Arbitration:
  - IDLE with `dp_alu_op`=`ALU_SUB`, A=10, B=4 -> ALU ports show SUB/10/4.
  - During RUN, the same datapath inputs are ignored and the ports show ADD/`acc`/`mc`.
- `RST` pulsed mid-RUN of 0x80000000×0x80000000 -> all outputs reset immediately, no `done`. A new `start` after release completes normally.
